// File: rtl/div_sequencer.sv
// Restoring shift-subtract unsigned divider, one quotient bit per
// SHIFTING/SUBTRACTING pair, start/ready handshake.
module div_sequencer #(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         ready,
  output logic         busy,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFTING,
    SUBTRACTING,
    STOPPED
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [N:0]      r_a;
  logic [N-1:0]    r_q;
  logic [N-1:0]    r_m;
  logic [CW-1:0]   r_count;
  logic [N-1:0]    r_quot;
  logic [N-1:0]    r_rem;
  logic            r_dbz;
  logic [N:0]      w_diff;
  logic [CW-1:0]   w_cnt_dec;
  logic            w_fits;
  logic            w_zero;

  assign w_diff    = r_a - {1'b0, r_m};
  assign w_fits    = ~w_diff[N];
  assign w_cnt_dec = r_count - CW'(1);
  assign w_zero    = (divisor == '0);
  assign quotient  = r_quot;
  assign remainder = r_rem;

  always_ff @(posedge clock) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = IDLE;
    ready       = 1'b0;
    busy        = 1'b0;
    div_by_zero = 1'b0;
    case (r_state)
      IDLE: begin
        w_next = IDLE;
        if (start) w_next = w_zero ? STOPPED : SHIFTING;
      end
      SHIFTING: begin
        busy   = 1'b1;
        w_next = SUBTRACTING;
      end
      SUBTRACTING: begin
        busy   = 1'b1;
        w_next = (w_cnt_dec == '0) ? STOPPED : SHIFTING;
      end
      STOPPED: begin
        ready       = 1'b1;
        div_by_zero = r_dbz;
        w_next      = STOPPED;
        if (start) w_next = w_zero ? STOPPED : SHIFTING;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_count <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, STOPPED: begin
          if (start) begin
            r_a     <= '0;
            r_q     <= dividend;
            r_m     <= divisor;
            r_count <= CW'(N);
            r_dbz   <= w_zero;
            // Divide by zero completes on the launch edge itself
            if (w_zero) begin
              r_quot <= '1;
              r_rem  <= dividend;
            end
          end
        end
        SHIFTING: begin
          {r_a, r_q} <= {r_a[N-1:0], r_q, 1'b0};
        end
        SUBTRACTING: begin
          if (w_fits) r_a <= w_diff;
          r_q[0]  <= w_fits;
          r_count <= w_cnt_dec;
          if (w_cnt_dec == '0) begin
            r_quot <= {r_q[N-1:1], w_fits};
            r_rem  <= w_fits ? w_diff[N-1:0] : r_a[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
